alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: req0 (core execute stage) and req1 (auxiliary unit, e.g. debug/address-gen).
- Arbitrates with valid/ready handshakes, drives the ALU operand/control inputs for the granted requester and captures the result in a one-entry response buffer.
- The response is returned on the winning requester's response channel.
- Sits between the requesters and the alu instance; the ALU itself is unchanged.

Parameters:
- DATA_W, 32, operand/result width; must equal `INSTR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- reqN_valid  in  1  request valid, N=0,1
- reqN_ready  out  1  request accepted this cycle when high with reqN_valid
- reqN_alu_ctrl  in  4  ALU opcode (`ADD, `SUBTRACT, `ALU_SLL, ...)
- reqN_alu_src  in  1  1 = use sign_ext as second operand
- reqN_src1, reqN_src2, reqN_sign_ext  in  DATA_W  operands
- rspN_valid  out  1  buffered result valid for requester N
- rspN_ready  in  1  requester N consumes result
- rsp_results  out  DATA_W  buffered ALU result (shared by both response channels)
- rsp_zero  out  1  buffered zero flag
- rsp_last_bit  out  1  buffered res_last_bit
- alu_ctrl_o  out  4  to ALU alu_ctrl
- alu_src_o  out  1  to ALU alu_src
- alu_src1_o, alu_src2_o, alu_sign_ext_o  out  DATA_W  to ALU operands
- alu_results_i  in  DATA_W  from ALU results
- alu_zero_i, alu_last_bit_i  in  1  from ALU zero / res_last_bit

Behaviour:
- Clocking: one clock; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - rsp0_valid = rsp1_valid = 0; rsp_results = 0; rsp_zero = 0; rsp_last_bit = 0.
  - last_grant = 1, so req0 wins the first contention.
  - State = EMPTY.
- State machine:
  - EMPTY: the buffer is free.
  - FULL: the buffer holds a result; the owner register (0/1) records which requester it belongs to.
- Buffer availability: buf_free = (state==EMPTY) | (state==FULL & rsp<owner>_ready).
- Grant (combinational, same cycle):
  - If buf_free and exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester that is not last_grant (round-robin).
  - reqN_ready = grant_N. At most one ready is high per cycle.
  - Neither ready is high when the buffer is not free.
- ALU drive:
  - While a grant is active, alu_*_o pass through the granted requester's fields combinationally.
  - With no grant, all alu_*_o = 0.
- Capture:
  - On a clock edge with a grant: the buffer loads alu_results_i, alu_zero_i and alu_last_bit_i; owner <= N; last_grant <= N; state <= FULL.
  - Latency: the request handshake in cycle T gives rspN_valid=1 in cycle T+1.
- Response:
  - rspN_valid = (state==FULL & owner==N).
  - On the edge where rspN_ready is high and no new grant occurs, state <= EMPTY.
  - Consume and new grant in the same cycle: the buffer reloads and stays FULL (back-to-back, throughput 1 op/cycle).
- rspN_ready is ignored when rspN_valid is low.
- Requesters hold their fields stable while valid is high and ready is low. A requester may drop valid before it is granted; nothing is captured in that case.
- Width: results pass through unmodified; no arithmetic in this block.
- Reset mid-operation: a buffered result is discarded, rsp*_valid goes to 0 on the next cycle, last_grant returns to 1, and in-flight requests are not acknowledged.
- Fairness: under continuous dual requests, grants alternate 0,1,0,1...

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: req0 always wins contention and the round-robin state is not used. last_grant is still updated but does not affect the grant.
- Undefined: round-robin as specified above.

Test Plan:
- Single request: req0 valid, `ADD, src1=5, src2=7, alu_src=0 -> req0_ready=1 at T; rsp0_valid=1 at T+1 with rsp_results=12, rsp_zero=0, rsp_last_bit=0; rsp1_valid stays 0.
- Immediate path: req1 `SUBTRACT, src1=9, sign_ext=9, alu_src=1 -> rsp_results=0, rsp_zero=1 on rsp1.
- Contention after reset: both valid every cycle, rsp ready held high -> grant order 0,1,0,1; 1 result/cycle. With ALU_ARB_FIXED_PRIO_EN defined -> grants 0,0,0 and req1_ready stays 0.
- Backpressure: rsp0_ready=0 while FULL and req1 valid -> req1_ready=0 and the buffer is held stable; raising rsp0_ready -> req1 granted in the same cycle, rsp1_valid next cycle.
- Shift pass-through: req0 `ALU_SRA, src1=0x80000000, src2=4 -> rsp_results=0xF8000000, rsp_last_bit=0.
- Reset mid-operation: rst_n=0 for one edge while FULL -> rsp0_valid=rsp1_valid=0; next contention grants req0 first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared combinational ALU, with a one-entry response buffer.
// Build option ALU_ARB_FIXED_PRIO_EN: req0 always wins contention instead of round-robin.

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

// state | meaning
// EMPTY | response buffer free, any request may be granted
// FULL  | buffer holds a result for requester 'owner'
module alu_arbiter #(
    parameter int DATA_W = `INSTR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_alu_ctrl,
    input  logic              req0_alu_src,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic [DATA_W-1:0] req0_sign_ext,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_alu_ctrl,
    input  logic              req1_alu_src,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    input  logic [DATA_W-1:0] req1_sign_ext,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_results,
    output logic              rsp_zero,
    output logic              rsp_last_bit,

    output logic [3:0]        alu_ctrl_o,
    output logic              alu_src_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [DATA_W-1:0] alu_sign_ext_o,
    input  logic [DATA_W-1:0] alu_results_i,
    input  logic              alu_zero_i,
    input  logic              alu_last_bit_i
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state;
    logic   owner;
    logic   last_grant;
    logic   owner_ready;
    logic   buf_free;
    logic   grant0;
    logic   grant1;

    assign owner_ready = owner ? rsp1_ready : rsp0_ready;
    assign buf_free    = (state == EMPTY) || (state == FULL && owner_ready);

    // Readies are held low during reset so in-flight requests are not acknowledged.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (buf_free && rst_n) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                grant0 = 1'b1;
`else
                grant0 = last_grant;
                grant1 = !last_grant;
`endif
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_ctrl_o     = '0;
        alu_src_o      = 1'b0;
        alu_src1_o     = '0;
        alu_src2_o     = '0;
        alu_sign_ext_o = '0;
        if (grant0) begin
            alu_ctrl_o     = req0_alu_ctrl;
            alu_src_o      = req0_alu_src;
            alu_src1_o     = req0_src1;
            alu_src2_o     = req0_src2;
            alu_sign_ext_o = req0_sign_ext;
        end else if (grant1) begin
            alu_ctrl_o     = req1_alu_ctrl;
            alu_src_o      = req1_alu_src;
            alu_src1_o     = req1_src1;
            alu_src2_o     = req1_src2;
            alu_sign_ext_o = req1_sign_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EMPTY;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_results  <= '0;
            rsp_zero     <= 1'b0;
            rsp_last_bit <= 1'b0;
        end else if (grant0 || grant1) begin
            state        <= FULL;
            owner        <= grant1;
            last_grant   <= grant1;
            rsp0_valid   <= grant0;
            rsp1_valid   <= grant1;
            rsp_results  <= alu_results_i;
            rsp_zero     <= alu_zero_i;
            rsp_last_bit <= alu_last_bit_i;
        end else if (state == FULL && owner_ready) begin
            state      <= EMPTY;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter; a small ALU model stands in for the real ALU.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;
    localparam logic [3:0] OP_SRA = 4'd3;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_ready, req0_alu_src;
    logic [3:0] req0_alu_ctrl;
    logic [W-1:0] req0_src1, req0_src2, req0_sign_ext;
    logic req1_valid, req1_ready, req1_alu_src;
    logic [3:0] req1_alu_ctrl;
    logic [W-1:0] req1_src1, req1_src2, req1_sign_ext;
    logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_results;
    logic rsp_zero, rsp_last_bit;
    logic [3:0] alu_ctrl_o;
    logic alu_src_o;
    logic [W-1:0] alu_src1_o, alu_src2_o, alu_sign_ext_o;
    logic [W-1:0] alu_results_i;
    logic alu_zero_i, alu_last_bit_i;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_alu_ctrl(req0_alu_ctrl),
        .req0_alu_src(req0_alu_src), .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req0_sign_ext(req0_sign_ext),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_alu_ctrl(req1_alu_ctrl),
        .req1_alu_src(req1_alu_src), .req1_src1(req1_src1), .req1_src2(req1_src2),
        .req1_sign_ext(req1_sign_ext),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_results(rsp_results), .rsp_zero(rsp_zero), .rsp_last_bit(rsp_last_bit),
        .alu_ctrl_o(alu_ctrl_o), .alu_src_o(alu_src_o), .alu_src1_o(alu_src1_o),
        .alu_src2_o(alu_src2_o), .alu_sign_ext_o(alu_sign_ext_o),
        .alu_results_i(alu_results_i), .alu_zero_i(alu_zero_i), .alu_last_bit_i(alu_last_bit_i)
    );

    // ALU model
    logic [W-1:0] op2;
    always_comb begin
        op2 = alu_src_o ? alu_sign_ext_o : alu_src2_o;
        case (alu_ctrl_o)
            OP_ADD:  alu_results_i = alu_src1_o + op2;
            OP_SUB:  alu_results_i = alu_src1_o - op2;
            OP_SLL:  alu_results_i = alu_src1_o << op2[4:0];
            OP_SRA:  alu_results_i = $unsigned($signed(alu_src1_o) >>> op2[4:0]);
            default: alu_results_i = '0;
        endcase
        alu_zero_i     = (alu_results_i == '0);
        alu_last_bit_i = alu_results_i[0];
    end

    typedef struct packed {
        logic         owner;
        logic [W-1:0] res;
        logic         zero;
        logic         last;
    } exp_t;

    typedef struct packed {
        logic [3:0]   ctrl;
        logic         src;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic [W-1:0] se;
        logic [W-1:0] res;
        logic         zero;
        logic         last;
    } vec_t;

    exp_t sb_q[$];
    int compared = 0;
    int mismatched = 0;
    int pushed = 0;
    int popped = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic own, input vec_t v);
        exp_t e;
        e.owner = own;
        e.res   = v.res;
        e.zero  = v.zero;
        e.last  = v.last;
        sb_q.push_back(e);
        pushed++;
    endtask

    task automatic drive0(input vec_t v);
        req0_alu_ctrl = v.ctrl; req0_alu_src = v.src;
        req0_src1 = v.s1; req0_src2 = v.s2; req0_sign_ext = v.se;
    endtask

    task automatic drive1(input vec_t v);
        req1_alu_ctrl = v.ctrl; req1_alu_src = v.src;
        req1_src1 = v.s1; req1_src2 = v.s2; req1_sign_ext = v.se;
    endtask

    // Monitor: pop and compare on every response handshake
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
            exp_t e;
            logic own;
            own = rsp1_valid;
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(own), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                popped++;
                chk("rsp_owner", 32'(own), 32'(e.owner));
                chk("rsp_results", rsp_results, e.res);
                chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                chk("rsp_last_bit", 32'(rsp_last_bit), 32'(e.last));
            end
        end
    end

    vec_t v_add  = '{OP_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1'b0};
    vec_t v_subi = '{OP_SUB, 1'b1, 32'd9, 32'd123, 32'd9, 32'd0, 1'b1, 1'b0};
    vec_t v_bp0  = '{OP_ADD, 1'b0, 32'd3, 32'd4, 32'd0, 32'd7, 1'b0, 1'b1};
    vec_t v_bp1  = '{OP_SUB, 1'b0, 32'd50, 32'd8, 32'd0, 32'd42, 1'b0, 1'b0};
    vec_t v_sra  = '{OP_SRA, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, 1'b0, 1'b0};
    vec_t v_hold = '{OP_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, 1'b0};
    vec_t v_rst0 = '{OP_SLL, 1'b0, 32'd3, 32'd2, 32'd0, 32'd12, 1'b0, 1'b0};
    vec_t v_rst1 = '{OP_ADD, 1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0, 1'b0};
    vec_t c0[4];
    vec_t c1[4];
    logic exp_g0[4];

    initial begin
        c0[0] = '{OP_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0, 1'b1};
        c0[1] = '{OP_ADD, 1'b0, 32'h10, 32'h20, 32'd0, 32'h30, 1'b0, 1'b0};
        c0[2] = '{OP_ADD, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0};
        c0[3] = '{OP_ADD, 1'b0, 32'd5, 32'd6, 32'd0, 32'd11, 1'b0, 1'b1};
        c1[0] = '{OP_SUB, 1'b0, 32'd100, 32'd1, 32'd0, 32'd99, 1'b0, 1'b1};
        c1[1] = '{OP_SUB, 1'b1, 32'd7, 32'd0, 32'd7, 32'd0, 1'b1, 1'b0};
        c1[2] = '{OP_SLL, 1'b0, 32'd1, 32'd31, 32'd0, 32'h8000_0000, 1'b0, 1'b0};
        c1[3] = '{OP_SUB, 1'b0, 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1};
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g0 = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
        exp_g0 = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        drive0(v_add); drive1(v_subi);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("reset_rsp_results", rsp_results, 32'd0);
        chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("reset_rsp_last_bit", 32'(rsp_last_bit), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_alu_src1", alu_src1_o, 32'd0);
        chk("idle_alu_ctrl", 32'(alu_ctrl_o), 32'd0);

        // single request on req0
        @(posedge clk); #1;
        req0_valid = 1'b1;
        @(negedge clk);
        chk("single_req0_ready", 32'(req0_ready), 32'd1);
        chk("single_req1_ready", 32'(req1_ready), 32'd0);
        chk("single_alu_src2", alu_src2_o, 32'd7);
        if (req0_ready) push_exp(1'b0, v_add);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("single_rsp1_valid", 32'(rsp1_valid), 32'd0);

        // immediate operand on req1
        @(posedge clk); #1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("imm_req1_ready", 32'(req1_ready), 32'd1);
        if (req1_ready) push_exp(1'b1, v_subi);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("imm_rsp1_valid", 32'(rsp1_valid), 32'd1);

        // contention: last_grant is 1 here, so req0 goes first
        begin
            int i0, i1;
            i0 = 0; i1 = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                req0_valid = 1'b1; req1_valid = 1'b1;
                drive0(c0[i0]); drive1(c1[i1]);
                @(negedge clk);
                chk($sformatf("cont%0d_req0_ready", c), 32'(req0_ready), 32'(exp_g0[c]));
                chk($sformatf("cont%0d_req1_ready", c), 32'(req1_ready), 32'(!exp_g0[c]));
                if (exp_g0[c]) begin push_exp(1'b0, c0[i0]); i0++; end
                else begin push_exp(1'b1, c1[i1]); i1++; end
            end
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
        end

        // backpressure on rsp0
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        drive0(v_bp0); drive1(v_bp1);
        req0_valid = 1'b1;
        @(negedge clk);
        chk("bp_req0_ready", 32'(req0_ready), 32'd1);
        if (req0_ready) push_exp(1'b0, v_bp0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_req1_ready_held", 32'(req1_ready), 32'd0);
            chk("bp_rsp_results_held", rsp_results, 32'd7);
            chk("bp_rsp0_valid_held", 32'(rsp0_valid), 32'd1);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_req1_ready_release", 32'(req1_ready), 32'd1);
        if (req1_ready) push_exp(1'b1, v_bp1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);

        // arithmetic shift pass-through
        @(posedge clk); #1;
        drive0(v_sra);
        req0_valid = 1'b1;
        @(negedge clk);
        chk("sra_req0_ready", 32'(req0_ready), 32'd1);
        if (req0_ready) push_exp(1'b0, v_sra);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);

        // reset while FULL; the held result must never be delivered
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        drive0(v_hold);
        req0_valid = 1'b1;
        @(negedge clk);
        chk("rst_hold_req0_ready", 32'(req0_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive0(v_rst0); drive1(v_rst1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("post_rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("post_rst_req0_ready", 32'(req0_ready), 32'd1);
        chk("post_rst_req1_ready", 32'(req1_ready), 32'd0);
        if (req0_ready) push_exp(1'b0, v_rst0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("sb_pop_count", 32'(popped), 32'(pushed));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        mismatched++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
